cache_axi_rd_arbiter: RTL
=========================

Name: cache_axi_rd_arbiter

Overview:
Shares the single AXI read master port between the icache refill path and the dcache refill path. One burst is in flight at a time. Write-back traffic goes from the dcache write FSM directly to the interconnect; this block only snoops the AW/B handshakes so that a dcache refill cannot overtake a pending write-back of the same line. It sits between both caches' refill logic and the top-level AXI bridge.

Parameters:
BURST_LEN, 4, beats per refill burst; m_arlen = BURST_LEN-1.

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
i_arvalid  in  1  icache refill request
i_araddr  in  32  icache refill address
i_arready  out  1  icache request accepted
i_rvalid  out  1  read beat valid for icache
i_rready  in  1  icache ready for a beat
d_arvalid  in  1  dcache refill request
d_araddr  in  32  dcache refill address
d_arready  out  1  dcache request accepted
d_rvalid  out  1  read beat valid for dcache
d_rready  in  1  dcache ready for a beat
m_arvalid  out  1  AXI AR valid
m_araddr  out  32  AXI AR address, line-aligned
m_arlen  out  8  constant BURST_LEN-1
m_arsize  out  3  constant 3'd2 (4 B/beat)
m_arready  in  1  AXI AR ready
m_rvalid  in  1  AXI R valid (m_rdata and m_rlast are wired straight to both caches)
m_rlast  in  1  AXI R last beat
m_rready  out  1  AXI R ready
m_awvalid  in  1  snooped write-back AW valid
m_awready  in  1  snooped AW ready
m_awaddr  in  32  snooped AW address
m_bvalid  in  1  snooped B valid
m_bready  in  1  snooped B ready

Behaviour:
- FSM has three states: IDLE, AR and R. On reset: state is IDLE, wb_pend=0, RR pointer selects dcache. All outputs are 0 except the constants m_arlen and m_arsize.
- Hazard tracker:
  - On an AW handshake, set wb_pend and latch wb_line = m_awaddr[31:4].
  - On a B handshake, clear wb_pend.
  - If an AW handshake and a B handshake occur in the same cycle, wb_pend stays 1 and wb_line takes the new address.
  - A dcache request is blocked while (wb_pend && d_araddr[31:4]==wb_line) or (m_awvalid && m_awaddr[31:4]==d_araddr[31:4]).
  - Icache requests are never blocked.
- IDLE:
  - Arbitrate among eligible requesters. The fixed rule is dcache over icache.
  - The winner's x_arready is driven high combinationally for exactly this cycle.
  - Latch owner and {addr[31:4],4'b0}, then go to AR. First m_arvalid appears at T+1 after the grant cycle T.
  - Requesters hold their address until x_arready is seen.
- AR: m_arvalid=1 with m_araddr stable until m_arready; then go to R. A grant can never be issued in AR or R.
- R:
  - m_rready = owner's x_rready.
  - Owner's x_rvalid = m_rvalid. The non-owner's x_rvalid = 0.
  - A beat handshake with m_rlast=1 returns to IDLE. Re-arbitration is possible in that IDLE cycle, so back-to-back bursts have a 1-cycle gap.
  - m_rlast is authoritative. The beat count is not checked.
- rst asserted mid-burst: return to IDLE next cycle. The burst is abandoned; the interconnect is reset by the same rst.

Optional Feature:
ARB_RR_EN: when defined, if both requesters are eligible, the one not granted last wins, and the RR pointer updates on each grant. A blocked dcache does not count as requesting. When undefined, fixed dcache priority applies.

Decomposition:
- Package cache_axi_pkg holds:
  - owner_e {OWN_I, OWN_D}
  - arb_state_e {IDLE, AR, R}
  - LINE_OFF_W=4
  - AXI_SIZE_4B=3'd2
- Sub-module wb_hazard_tracker holds wb_pend/wb_line and produces d_blocked.

Test Plan:
1. Only i_arvalid with 0x1C000014: i_arready=1 at T; at T+1 m_arvalid=1, m_araddr=0x1C000010, m_arlen=3, m_arsize=2. Four beats go to i_rvalid; d_rvalid stays 0.
2. i_arvalid and d_arvalid rise in the same cycle, no macro: dcache is granted first; icache is granted in the IDLE cycle after dcache's rlast handshake.
3. AW handshake at 0x00001230, then d_arvalid at 0x00001238 together with i_arvalid: icache is served while dcache is blocked. After the B handshake, d_arready=1 in the next IDLE cycle.
4. m_arready held 0 for 5 cycles: m_arvalid and m_araddr stay stable. Owner rready=0 gives m_rready=0 and no beat is consumed.
5. rst=1 during beat 2: next cycle state is IDLE, all handshake outputs are 0 and wb_pend=0.
6. ARB_RR_EN defined, both requesters continuously requesting: grants alternate D, I, D, I. Without the macro, the grant order is D, D, D.

Source files
------------

// File: rtl/cache_axi_pkg.sv
// Shared types and constants for the cache AXI read arbiter slice.
package cache_axi_pkg;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AR   = 2'd1,
        R    = 2'd2
    } arb_state_e;

    localparam int         LINE_OFF_W  = 4;
    localparam logic [2:0] AXI_SIZE_4B = 3'd2;

    function automatic logic [31:0] line_align(input logic [31:0] addr);
        return {addr[31:LINE_OFF_W], {LINE_OFF_W{1'b0}}};
    endfunction

endpackage

// File: rtl/wb_hazard_tracker.sv
// Remembers the line of the outstanding dcache write-back and flags a dcache
// refill that would read that line before the write has completed.
module wb_hazard_tracker
    import cache_axi_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   aw_valid_i,
    input  logic                   aw_ready_i,
    input  logic [31-LINE_OFF_W:0] aw_line_i,
    input  logic                   b_valid_i,
    input  logic                   b_ready_i,
    input  logic [31-LINE_OFF_W:0] rd_line_i,
    output logic                   blocked_o
);

    logic                   wb_pend_q, wb_pend_d;
    logic [31-LINE_OFF_W:0] wb_line_q, wb_line_d;
    logic                   aw_hs, b_hs;

    assign aw_hs = aw_valid_i && aw_ready_i;
    assign b_hs  = b_valid_i && b_ready_i;

    // A new AW wins over a B in the same cycle: the newer write is still pending.
    always_comb begin
        wb_pend_d = wb_pend_q;
        wb_line_d = wb_line_q;
        if (aw_hs) begin
            wb_pend_d = 1'b1;
            wb_line_d = aw_line_i;
        end else if (b_hs) begin
            wb_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wb_pend_q <= 1'b0;
            wb_line_q <= '0;
        end else begin
            wb_pend_q <= wb_pend_d;
            wb_line_q <= wb_line_d;
        end
    end

    assign blocked_o = (wb_pend_q && (rd_line_i == wb_line_q)) ||
                       (aw_valid_i && (aw_line_i == rd_line_i));

endmodule

// File: rtl/cache_axi_rd_arbiter.sv
// Shares one AXI read master between icache and dcache refills, one burst at a time.
// Define ARB_RR_EN for round-robin arbitration; otherwise dcache has fixed priority.
module cache_axi_rd_arbiter
    import cache_axi_pkg::*;
#(
    parameter int BURST_LEN = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_arvalid,
    input  logic [31:0] i_araddr,
    output logic        i_arready,
    output logic        i_rvalid,
    input  logic        i_rready,
    input  logic        d_arvalid,
    input  logic [31:0] d_araddr,
    output logic        d_arready,
    output logic        d_rvalid,
    input  logic        d_rready,
    output logic        m_arvalid,
    output logic [31:0] m_araddr,
    output logic [7:0]  m_arlen,
    output logic [2:0]  m_arsize,
    input  logic        m_arready,
    input  logic        m_rvalid,
    input  logic        m_rlast,
    output logic        m_rready,
    input  logic        m_awvalid,
    input  logic        m_awready,
    input  logic [31:0] m_awaddr,
    input  logic        m_bvalid,
    input  logic        m_bready
);

    arb_state_e  state_q, state_d;
    owner_e      owner_q, owner_d;
    owner_e      winner;
    logic [31:0] addr_q, addr_d;
    logic        d_blocked, d_req, i_req, grant, sel_rready;
    logic        unused_awaddr_lo;

    assign unused_awaddr_lo = ^m_awaddr[LINE_OFF_W-1:0];

    wb_hazard_tracker u_wb_hazard (
        .clk_i      (clk),
        .rst_i      (rst),
        .aw_valid_i (m_awvalid),
        .aw_ready_i (m_awready),
        .aw_line_i  (m_awaddr[31:LINE_OFF_W]),
        .b_valid_i  (m_bvalid),
        .b_ready_i  (m_bready),
        .rd_line_i  (d_araddr[31:LINE_OFF_W]),
        .blocked_o  (d_blocked)
    );

    // A blocked dcache is treated as not requesting at all.
    assign d_req = d_arvalid && !d_blocked;
    assign i_req = i_arvalid;
    assign grant = (state_q == IDLE) && (d_req || i_req) && !rst;

`ifdef ARB_RR_EN
    owner_e rr_q, rr_d;

    always_comb begin
        if (d_req && i_req) winner = rr_q;
        else                winner = d_req ? OWN_D : OWN_I;
    end

    always_comb begin
        rr_d = rr_q;
        if (grant) rr_d = (winner == OWN_D) ? OWN_I : OWN_D;
    end

    always_ff @(posedge clk) begin
        if (rst) rr_q <= OWN_D;
        else     rr_q <= rr_d;
    end
`else
    always_comb begin
        winner = d_req ? OWN_D : OWN_I;
    end
`endif

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        addr_d     = addr_q;
        i_arready  = 1'b0;
        d_arready  = 1'b0;
        m_arvalid  = 1'b0;
        m_rready   = 1'b0;
        i_rvalid   = 1'b0;
        d_rvalid   = 1'b0;
        sel_rready = (owner_q == OWN_D) ? d_rready : i_rready;
        unique case (state_q)
            IDLE: begin
                if (grant) begin
                    owner_d   = winner;
                    addr_d    = line_align((winner == OWN_D) ? d_araddr : i_araddr);
                    i_arready = (winner == OWN_I);
                    d_arready = (winner == OWN_D);
                    state_d   = AR;
                end
            end
            AR: begin
                m_arvalid = 1'b1;
                if (m_arready) state_d = R;
            end
            R: begin
                // Only rlast ends the burst; the beat count is never tracked.
                m_rready = sel_rready;
                i_rvalid = (owner_q == OWN_I) && m_rvalid;
                d_rvalid = (owner_q == OWN_D) && m_rvalid;
                if (m_rvalid && sel_rready && m_rlast) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= OWN_I;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
        end
    end

    assign m_araddr = addr_q;
    assign m_arlen  = 8'(BURST_LEN - 1);
    assign m_arsize = AXI_SIZE_4B;

endmodule
